// File: rtl/matb_reader_if.sv
// Bundle of control, BRAM read-port and output-stream signals for matb_reader.
// The stream transfers one element at each rising edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, the producer holds m_data/m_row/m_col/m_last stable.
interface matb_reader_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          start;
    logic          wr_done;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [7:0]    m_row;
    logic [7:0]    m_col;
    logic          m_last;
    logic [1:0]    dbg_state;

    modport master (
        input  start, wr_done, mem_dout, m_ready,
        output busy, done, mem_addr, m_valid, m_data, m_row, m_col, m_last, dbg_state
    );

    modport slave (
        output start, wr_done, mem_dout, m_ready,
        input  busy, done, mem_addr, m_valid, m_data, m_row, m_col, m_last, dbg_state
    );
endinterface

// File: rtl/matb_reader.sv
// Streams the P x M B-matrix out of a 1-cycle-latency BRAM as (value, row, col) elements,
// using one inflight read slot plus a 2-entry buffer to sustain one element per cycle.
module matb_reader #(
    parameter int P         = 4,
    parameter int M         = 3,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int BASE      = 0,
    parameter int ROW_MAJOR = 0
) (
    input  logic          clk,
    input  logic          reset,
    matb_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_WR = 2'd1,
        S_READ    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_issue;
    logic          w_pop;
    logic          w_push;
    logic          w_valid;
    logic          w_iss_last;
    logic          w_done_next;
    logic [1:0]    w_occ;

    logic [AW-1:0] r_addr;
    logic [7:0]    r_iss_row;
    logic [7:0]    r_iss_col;
    logic          r_inflight;
    logic [7:0]    r_inf_row;
    logic [7:0]    r_inf_col;
    logic          r_inf_last;
    logic          r_done;

    logic [DW-1:0] r_fifo_data [2];
    logic [7:0]    r_fifo_row  [2];
    logic [7:0]    r_fifo_col  [2];
    logic          r_fifo_last [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_count;

    assign w_valid    = (r_count != 2'd0);
    assign w_pop      = w_valid && bus.m_ready;
    assign w_push     = r_inflight;
    assign w_occ      = r_count + {1'b0, r_inflight};
    assign w_iss_last = (r_iss_row == 8'(P - 1)) && (r_iss_col == 8'(M - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An issue is allowed when the read it starts is guaranteed a buffer slot at capture time.
    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (bus.wr_done) w_next = S_READ;
            end
            S_READ: begin
                w_issue = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
                if (w_issue && w_iss_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                    w_next      = S_IDLE;
                    w_done_next = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Address and index counters describe the next element to be issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_iss_row <= '0;
            r_iss_col <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_addr    <= AW'(BASE);
            r_iss_row <= '0;
            r_iss_col <= '0;
        end else if (w_issue) begin
            if (ROW_MAJOR != 0) begin
                if (r_iss_col == 8'(M - 1)) begin
                    r_iss_col <= '0;
                    r_iss_row <= r_iss_row + 8'd1;
                    r_addr    <= AW'(BASE) + AW'(r_iss_row) + AW'(1);
                end else begin
                    r_iss_col <= r_iss_col + 8'd1;
                    r_addr    <= r_addr + AW'(P);
                end
            end else begin
                if (r_iss_row == 8'(P - 1)) begin
                    r_iss_row <= '0;
                    r_iss_col <= r_iss_col + 8'd1;
                end else begin
                    r_iss_row <= r_iss_row + 8'd1;
                end
                r_addr <= r_addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_inf_row  <= '0;
            r_inf_col  <= '0;
            r_inf_last <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_done     <= w_done_next;
            if (w_issue) begin
                r_inf_row  <= r_iss_row;
                r_inf_col  <= r_iss_col;
                r_inf_last <= w_iss_last;
            end
        end
    end

    // Read data is captured the edge after its issue, tagged with the indices saved at issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_row[0]  <= '0;
            r_fifo_row[1]  <= '0;
            r_fifo_col[0]  <= '0;
            r_fifo_col[1]  <= '0;
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.mem_dout;
                r_fifo_row[r_wr_ptr]  <= r_inf_row;
                r_fifo_col[r_wr_ptr]  <= r_inf_col;
                r_fifo_last[r_wr_ptr] <= r_inf_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.mem_addr  = r_addr;
    assign bus.m_valid   = w_valid;
    assign bus.m_data    = r_fifo_data[r_rd_ptr];
    assign bus.m_row     = r_fifo_row[r_rd_ptr];
    assign bus.m_col     = r_fifo_col[r_rd_ptr];
    assign bus.m_last    = r_fifo_last[r_rd_ptr];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule
